// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester and SPI core signals shared by the SPI arbiter
interface spi_arbiter_if #(
  parameter int N = 3
);
  logic [N-1:0]    req;
  logic [N-1:0]    hold;
  logic [N-1:0]    fast_in;
  logic [32*N-1:0] tx_in;
  logic [N-1:0]    ack;
  logic [31:0]     rx_out;
  logic [N-1:0]    ss_n;
  logic            busy;
  logic            spi_start;
  logic            spi_fast;
  logic [31:0]     spi_tx;
  logic [31:0]     spi_rx;
  logic            spi_rdy;

  // arbiter side
  modport slave (
    input  req, hold, fast_in, tx_in, spi_rx, spi_rdy,
    output ack, rx_out, ss_n, busy, spi_start, spi_fast, spi_tx
  );

  // requesters plus SPI core side
  modport master (
    output req, hold, fast_in, tx_in, spi_rx, spi_rdy,
    input  ack, rx_out, ss_n, busy, spi_start, spi_fast, spi_tx
  );
endinterface

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin sharing of one SPI master core with per-device slave selects
module spi_arbiter #(
  parameter int N      = 3,
  parameter int CS_GAP = 2
) (
  input logic        clk,
  input logic        rst,
  spi_arbiter_if.slave bus
);
  localparam int W  = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, DONE, HELD, GAP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   ptr;
  logic [W-1:0]   owner;
  logic [W-1:0]   grant_idx;
  logic           grant_found;
  logic [W-1:0]   scan_idx;
  logic [GW-1:0]  gap_cnt;
  logic           gap_last;
  logic           owner_req;
  logic           owner_hold;
  logic           fast_sel;
  logic [31:0]    tx_sel;
  logic           latch_word;
  logic           sel_active;
  logic           fast_q;
  logic [31:0]    tx_q;
  logic [31:0]    rx_q;

  assign gap_last   = (gap_cnt == GW'(CS_GAP - 1));
  assign latch_word = (state == SETUP) || ((state == HELD) && owner_req);
  assign sel_active = (state == SETUP) || (state == START) || (state == WAIT) ||
                      (state == DONE)  || (state == HELD);

  // round-robin scan upward from ptr; the lowest offset with a request wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = W'((int'(ptr) + k) % N);
      if (bus.req[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // owner's request, hold, mode and transmit word
  always_comb begin
    owner_req  = 1'b0;
    owner_hold = 1'b0;
    fast_sel   = 1'b0;
    tx_sel     = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == W'(i)) begin
        owner_req  = bus.req[i];
        owner_hold = bus.hold[i];
        fast_sel   = bus.fast_in[i];
        tx_sel     = bus.tx_in[32*i +: 32];
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = SETUP;
      SETUP:   state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (bus.spi_rdy) state_nxt = DONE;
      DONE:    state_nxt = owner_hold ? HELD : GAP;
      HELD: begin
        if (owner_req)       state_nxt = START;
        else if (!owner_hold) state_nxt = GAP;
      end
      GAP:     if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grant bookkeeping, word latching, receive capture and chip-select gap timing
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr     <= '0;
      owner   <= '0;
      gap_cnt <= '0;
      fast_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      if ((state == IDLE) && grant_found) begin
        owner <= grant_idx;
        ptr   <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
      end
      if (latch_word) begin
        fast_q <= fast_sel;
        tx_q   <= tx_sel;
      end
      if ((state == WAIT) && bus.spi_rdy) begin
        rx_q <= bus.spi_rx;
      end
      if (state == GAP) begin
        gap_cnt <= gap_last ? '0 : gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.spi_start = (state == START);
    bus.spi_fast  = fast_q;
    bus.spi_tx    = tx_q;
    bus.rx_out    = rx_q;
    bus.ss_n      = '1;
    bus.ack       = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == W'(i)) begin
        bus.ss_n[i] = !sel_active;
        bus.ack[i]  = (state == DONE);
      end
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for the SPI arbiter
module tb_spi_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  spi_arbiter_if #(.N(3)) bus ();

  spi_arbiter #(.N(3), .CS_GAP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI core model: MOSI looped to MISO, byte mode returns only the low byte
  int          core_cnt;
  logic [31:0] core_word;
  always @(posedge clk) begin
    if (!rst) begin
      bus.spi_rdy <= 1'b1;
      bus.spi_rx  <= '0;
      core_cnt    <= 0;
      core_word   <= '0;
    end else if (bus.spi_start) begin
      bus.spi_rdy <= 1'b0;
      core_cnt    <= bus.spi_fast ? 4 : 8;
      core_word   <= bus.spi_fast ? bus.spi_tx : {24'h0, bus.spi_tx[7:0]};
    end else if (!bus.spi_rdy) begin
      if (core_cnt == 1) begin
        bus.spi_rdy <= 1'b1;
        bus.spi_rx  <= core_word;
      end
      core_cnt <= core_cnt - 1;
    end
  end

  typedef struct {
    int          idx;
    logic        fast;
    logic [31:0] tx;
    logic [31:0] rx;
    logic [2:0]  ss;
    logic [2:0]  ack;
  } vec_t;

  vec_t vecs[4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus.ack != 3'b000) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic do_xfer(input vec_t v);
    bit seen;
    bus.req[v.idx]           = 1'b1;
    bus.fast_in[v.idx]       = v.fast;
    bus.tx_in[v.idx*32 +: 32] = v.tx;
    tick;
    check("setup_ss", {29'h0, bus.ss_n}, {29'h0, v.ss});
    check("setup_start", {31'h0, bus.spi_start}, 32'd0);
    tick;
    check("start_pulse", {31'h0, bus.spi_start}, 32'd1);
    check("start_tx", bus.spi_tx, v.tx);
    check("start_fast", {31'h0, bus.spi_fast}, {31'h0, v.fast});
    tick;
    check("start_single", {31'h0, bus.spi_start}, 32'd0);
    wait_ack(seen);
    check("ack_seen", {31'h0, seen}, 32'd1);
    check("ack_bits", {29'h0, bus.ack}, {29'h0, v.ack});
    check("rx_out", bus.rx_out, v.rx);
    check("done_ss", {29'h0, bus.ss_n}, {29'h0, v.ss});
    bus.req[v.idx] = 1'b0;
    tick;
    check("gap1_ss", {29'h0, bus.ss_n}, 32'h7);
    check("gap1_ack", {29'h0, bus.ack}, 32'd0);
    check("gap1_busy", {31'h0, bus.busy}, 32'd1);
    tick;
    check("gap2_ss", {29'h0, bus.ss_n}, 32'h7);
    check("gap2_busy", {31'h0, bus.busy}, 32'd1);
    tick;
    check("idle_busy", {31'h0, bus.busy}, 32'd0);
  endtask

  task automatic run_rr(input logic [2:0] r, input int n_exp, input int e0, input int e1, input int e2);
    int order[$];
    int bad;
    int exp_o;
    bad     = 0;
    bus.req = r;
    for (int c = 0; c < 300 && (bus.req != 3'b000 || bus.busy); c++) begin
      tick;
      if ($countones(~bus.ss_n) > 1) bad++;
      if (bus.ack != 3'b000) begin
        for (int i = 0; i < 3; i++) begin
          if (bus.ack[i]) begin
            order.push_back(i);
            bus.req[i] = 1'b0;
          end
        end
      end
    end
    check("rr_drained", {28'h0, bus.busy, bus.req}, 32'd0);
    check("rr_count", order.size(), n_exp);
    for (int k = 0; k < n_exp && k < order.size(); k++) begin
      exp_o = (k == 0) ? e0 : ((k == 1) ? e1 : e2);
      check("rr_order", order[k], exp_o);
    end
    check("rr_onecold", bad, 0);
  endtask

  initial begin
    bit seen;
    vec_t v;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.req     = '0;
    bus.hold    = '0;
    bus.fast_in = '0;
    bus.tx_in   = '0;

    vecs[0] = '{0, 1'b0, 32'h000000A5, 32'h000000A5, 3'b110, 3'b001};
    vecs[1] = '{1, 1'b1, 32'h12345678, 32'h12345678, 3'b101, 3'b010};
    vecs[2] = '{2, 1'b0, 32'hDEADBEEF, 32'h000000EF, 3'b011, 3'b100};
    vecs[3] = '{0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 3'b110, 3'b001};

    // reset with random inputs
    for (int c = 0; c < 4; c++) begin
      bus.req     = 3'($urandom);
      bus.hold    = 3'($urandom);
      bus.fast_in = 3'($urandom);
      bus.tx_in   = {$urandom, $urandom, $urandom};
      tick;
      check("rst_ss", {29'h0, bus.ss_n}, 32'h7);
      check("rst_ack", {29'h0, bus.ack}, 32'd0);
      check("rst_busy", {31'h0, bus.busy}, 32'd0);
      check("rst_start", {31'h0, bus.spi_start}, 32'd0);
      check("rst_rx", bus.rx_out, 32'd0);
    end
    bus.req     = '0;
    bus.hold    = '0;
    bus.fast_in = '0;
    bus.tx_in   = '0;
    rst         = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      check("post_rst_ss", {29'h0, bus.ss_n}, 32'h7);
      check("post_rst_busy", {31'h0, bus.busy}, 32'd0);
      check("post_rst_tx", bus.spi_tx, 32'd0);
      check("post_rst_fast", {31'h0, bus.spi_fast}, 32'd0);
    end

    // round robin from ptr=0
    run_rr(3'b111, 3, 0, 1, 2);
    run_rr(3'b101, 2, 0, 2, -1);

    // table of single uncontended transfers
    for (int i = 0; i < 4; i++) begin
      do_xfer(vecs[i]);
    end

    // hold: requester 1 sends two words while requester 0 waits
    bus.req      = 3'b011;
    bus.hold     = 3'b010;
    bus.fast_in  = 3'b010;
    bus.tx_in    = {32'h0, 32'h12345678, 32'h00000055};
    tick;
    check("hold_setup_ss", {29'h0, bus.ss_n}, 32'h5);
    wait_ack(seen);
    check("hold_ack1_seen", {31'h0, seen}, 32'd1);
    check("hold_ack1", {29'h0, bus.ack}, 32'h2);
    check("hold_rx1", bus.rx_out, 32'h12345678);
    bus.tx_in[63:32] = 32'hCAFEF00D;
    tick;
    check("hold_held_ss", {29'h0, bus.ss_n}, 32'h5);
    check("hold_held_ack", {29'h0, bus.ack}, 32'd0);
    tick;
    check("hold_start2", {31'h0, bus.spi_start}, 32'd1);
    check("hold_tx2", bus.spi_tx, 32'hCAFEF00D);
    check("hold_fast2", {31'h0, bus.spi_fast}, 32'd1);
    check("hold_start2_ss", {29'h0, bus.ss_n}, 32'h5);
    wait_ack(seen);
    check("hold_ack2_seen", {31'h0, seen}, 32'd1);
    check("hold_ack2", {29'h0, bus.ack}, 32'h2);
    check("hold_rx2", bus.rx_out, 32'hCAFEF00D);
    check("hold_done2_ss", {29'h0, bus.ss_n}, 32'h5);
    bus.req[1] = 1'b0;
    tick;
    check("hold_park_ss", {29'h0, bus.ss_n}, 32'h5);
    check("hold_park_busy", {31'h0, bus.busy}, 32'd1);
    bus.hold[1] = 1'b0;
    tick;
    check("rel_gap1_ss", {29'h0, bus.ss_n}, 32'h7);
    tick;
    check("rel_gap2_ss", {29'h0, bus.ss_n}, 32'h7);
    tick;
    check("rel_idle_ss", {29'h0, bus.ss_n}, 32'h7);
    check("rel_idle_busy", {31'h0, bus.busy}, 32'd0);
    tick;
    check("rel_grant0_ss", {29'h0, bus.ss_n}, 32'h6);
    wait_ack(seen);
    check("rel_ack0_seen", {31'h0, seen}, 32'd1);
    check("rel_ack0", {29'h0, bus.ack}, 32'h1);
    check("rel_rx0", bus.rx_out, 32'h00000055);
    bus.req     = '0;
    bus.fast_in = '0;
    tick;
    tick;
    tick;
    check("rel_drain_busy", {31'h0, bus.busy}, 32'd0);

    // stability of latched mode and word during WAIT
    bus.req[2]      = 1'b1;
    bus.fast_in[2]  = 1'b0;
    bus.tx_in[95:64] = 32'h0000003C;
    tick;
    tick;
    check("stab_start_tx", bus.spi_tx, 32'h0000003C);
    tick;
    bus.fast_in[2]   = 1'b1;
    bus.tx_in[95:64] = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      tick;
      check("stab_fast", {31'h0, bus.spi_fast}, 32'd0);
      check("stab_tx", bus.spi_tx, 32'h0000003C);
      check("stab_no_ack", {29'h0, bus.ack}, 32'd0);
    end
    wait_ack(seen);
    check("stab_ack_seen", {31'h0, seen}, 32'd1);
    check("stab_ack", {29'h0, bus.ack}, 32'h4);
    check("stab_rx", bus.rx_out, 32'h0000003C);
    bus.req     = '0;
    bus.fast_in = '0;
    tick;
    tick;
    tick;
    check("stab_drain_busy", {31'h0, bus.busy}, 32'd0);

    // reset while waiting on the SPI core
    bus.req[1]       = 1'b1;
    bus.tx_in[63:32] = 32'h00000077;
    tick;
    tick;
    tick;
    check("abort_wait_ss", {29'h0, bus.ss_n}, 32'h5);
    rst = 1'b0;
    tick;
    check("abort_ss", {29'h0, bus.ss_n}, 32'h7);
    check("abort_ack", {29'h0, bus.ack}, 32'd0);
    check("abort_busy", {31'h0, bus.busy}, 32'd0);
    check("abort_start", {31'h0, bus.spi_start}, 32'd0);
    check("abort_rx", bus.rx_out, 32'd0);
    bus.req = '0;
    tick;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      check("abort_quiet_ack", {29'h0, bus.ack}, 32'd0);
    end
    v = '{1, 1'b1, 32'h0BADF00D, 32'h0BADF00D, 3'b101, 3'b010};
    do_xfer(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the single SPI master core between N requesters (e.g. SD card, flash, display) and sequences each transfer: chip-select setup, start pulse, completion wait, result return, chip-select gap. It sits between the requesting peripherals and the SPI core's start/fast/dataTx/dataRx/rdy interface. It also owns the per-device active-low slave selects. Arbitration is round-robin; a requester may hold the bus across several transfers for multi-word commands.

## Interface
- N, 3: number of requesters (2..8)
- CS_GAP, 2: cycles all slave selects stay high between a released owner and the next grant (≥1)

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- req  in  N  per-requester transfer request (level)
- hold  in  N  keep ownership and slave select asserted after the current transfer
- fast_in  in  N  per-requester fast (32-bit word) / slow (byte) mode
- tx_in  in  32*N  transmit data; requester i at [32i+31:32i]
- ack  out  N  one-cycle pulse to the owner: transfer complete, rx_out valid
- rx_out  out  32  received data, valid when any ack bit is high, held until the next capture
- ss_n  out  N  active-low slave selects; at most one low
- busy  out  1  high whenever state ≠ IDLE
- spi_start  out  1  start pulse to the SPI core
- spi_fast  out  1  fast select to the SPI core
- spi_tx  out  32  transmit word to the SPI core
- spi_rx  in  32  receive word from the SPI core
- spi_rdy  in  1  SPI core ready

## Operation
- States: IDLE, SETUP, START, WAIT, DONE, HELD, GAP.
- IDLE: if any req bit is high, grant the first set bit searching upward from ptr, wrapping mod N. Set owner=i and ptr=(i+1) mod N, then go to SETUP.
- SETUP: ss_n[owner]=0. Latch fast_in[owner]→spi_fast and tx_in[owner]→spi_tx. Go to START.
- START: spi_start=1 for exactly this cycle. Go to WAIT.
- WAIT: when spi_rdy=1, capture spi_rx into rx_out and go to DONE. Otherwise stay in WAIT.
- DONE: ack[owner]=1. If hold[owner]=1, go to HELD. Otherwise go to GAP.
- HELD: ss_n[owner] stays 0 and other requests are ignored.
  - If req[owner]=1: latch fast/tx and go to START.
  - Else if hold[owner]=0: go to GAP.
  - Else stay in HELD.
- GAP: ss_n all 1 for CS_GAP cycles (counter), then go to IDLE.
- spi_fast and spi_tx are registers. They change only on the latch events above, so they stay stable for the whole transfer regardless of input changes.
- Requester protocol: each requester keeps req high until it sees ack, and req must be low in the cycle after ack unless it wants another transfer. Changing tx_in/fast_in while req is high is allowed; values are sampled only at latch points.
- Outside SETUP..HELD all ss_n bits are 1. ss_n[owner] is 0 in SETUP, START, WAIT, DONE and HELD.
- A hold bit on a non-owner has no effect.
- Reset (rst=0 at an edge), from any state including mid-WAIT:
  - state=IDLE, ptr=0, owner=0, GAP counter=0
  - ss_n=all 1, ack=0, spi_start=0, busy=0
  - spi_fast=0, spi_tx=0, rx_out=0
  - No ack is issued for an aborted transfer.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from req to any output.
- Uncontended latency: req high in IDLE at cycle 0 → ss_n low at cycle 1 (SETUP) → spi_start high at cycle 2.
- spi_rdy drops the cycle after START; WAIT samples it from its first cycle.
- spi_rdy=1 seen in WAIT at cycle k → ack and valid rx_out at cycle k+1.
- Held back-to-back transfers: DONE at k+1 → HELD at k+2 with req high → spi_start at k+3. ss_n stays low throughout.
- Release: after DONE or HELD, ss_n is high for exactly CS_GAP cycles before IDLE. The earliest next SETUP is CS_GAP+2 cycles after DONE.
- Simultaneous requests are resolved only in IDLE. A requester asserting req during another owner's transfer waits, and is granted within N grants.

## Test plan
- Reset: hold rst=0 with random inputs → ss_n=all 1, ack=0, busy=0, spi_start=0, rx_out=0. Release rst with req=0 → all stay at those values.
- Single slow transfer, using the SPI core model with MOSI looped to MISO: req[0], tx=0x000000A5, fast=0 → spi_start at cycle 2; ss_n=3'b110 until ack[0]; rx_out=0x000000A5; then ss_n=3'b111 for 2 cycles and busy drops.
- Round-robin: req=3'b111, hold=0 → acks in order 0,1,2. Then re-assert req[0] and req[2] together with ptr=0 → 0 then 2. Only one ss_n bit is ever low.
- Hold: requester 1 with hold=1 sends fast words 0x12345678 then 0xCAFEF00D, while req[0] stays high throughout → ss_n[1] stays low between the words and rx_out echoes each word. Requester 0 is granted only after hold[1] drops and the CS_GAP gap has elapsed.
- Stability: toggle fast_in[owner] and tx_in[owner] during WAIT → spi_fast and spi_tx unchanged until the next latch point.
- Reset mid-transfer: rst=0 in WAIT → next cycle ss_n=all 1, no ack. A new req after rst=1 completes normally.
